// File: rtl/input_buffer_b2_loader.sv
`default_nettype none
// ============================================================================
// Module   : input_buffer_b2_loader
// Purpose  : Round-robin write loader for the block-2 input buffer banks.
// Revision : 1.0
// ============================================================================

module input_buffer_b2_loader #(
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 29
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    // Consumer release pulse; "release" itself is a reserved word.
    input  logic                             buf_release,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  wr_din,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0]  wr_addr,
    output logic [NUM_BANKS-1:0]             wr_wea,
    output logic [NUM_BANKS-1:0]             wr_ena,
    output logic [7:0]                       fill_cnt,
    output logic                             buf_full,
    output logic                             frame_done
);

    localparam int C_PTR_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int C_FRAME_LEN = NUM_BANKS * DEPTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                  r_state;
    logic [C_PTR_W-1:0]      r_bank_ptr;
    logic [ADDR_WIDTH-1:0]   r_addr_cnt;

    logic                    w_accept;
    logic                    w_last_word;
    logic                    w_bank_wrap;

    // A start pulse blocks acceptance so the beat cannot land in the old frame.
    assign in_ready    = (r_state == S_FILL) && !start;
    assign w_accept    = in_valid && in_ready;
    assign w_last_word = (fill_cnt == 8'(C_FRAME_LEN - 1));
    assign w_bank_wrap = (r_bank_ptr == C_PTR_W'(NUM_BANKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bank_ptr <= '0;
            r_addr_cnt <= '0;
            fill_cnt   <= 8'd0;
            buf_full   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                r_state    <= S_FILL;
                r_bank_ptr <= '0;
                r_addr_cnt <= '0;
                fill_cnt   <= 8'd0;
                buf_full   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_FILL: begin
                        if (w_accept) begin
                            fill_cnt   <= fill_cnt + 8'd1;
                            r_bank_ptr <= w_bank_wrap ? '0 : r_bank_ptr + 1'b1;
                            if (w_bank_wrap && !w_last_word) begin
                                r_addr_cnt <= r_addr_cnt + 1'b1;
                            end
                            if (w_last_word) begin
                                r_state    <= S_FULL;
                                buf_full   <= 1'b1;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        if (buf_release) begin
                            r_state  <= S_IDLE;
                            buf_full <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Per-bank write port registers; unselected banks keep their last din/addr.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  w_sel;
        logic                  r_en;
        logic [DATA_WIDTH-1:0] r_din;
        logic [ADDR_WIDTH-1:0] r_addr;

        assign w_sel = w_accept && (r_bank_ptr == C_PTR_W'(b));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_en   <= 1'b0;
                r_din  <= '0;
                r_addr <= '0;
            end else begin
                r_en <= w_sel;
                if (w_sel) begin
                    r_din  <= in_data;
                    r_addr <= r_addr_cnt;
                end
            end
        end

        assign wr_ena[b]                                = r_en;
        assign wr_wea[b]                                = r_en;
        assign wr_din[b*DATA_WIDTH +: DATA_WIDTH]       = r_din;
        assign wr_addr[b*ADDR_WIDTH +: ADDR_WIDTH]      = r_addr;
    end

endmodule

`default_nettype wire

// File: tb/tb_input_buffer_b2_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_buffer_b2_loader
// Purpose  : Directed table-driven bench for the block-2 buffer loader.
// Revision : 1.0
// ============================================================================

module tb_input_buffer_b2_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         buf_release;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [255:0] wr_din;
    logic [39:0]  wr_addr;
    logic [7:0]   wr_wea;
    logic [7:0]   wr_ena;
    logic [7:0]   fill_cnt;
    logic         buf_full;
    logic         frame_done;

    input_buffer_b2_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .buf_release (buf_release),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_din      (wr_din),
        .wr_addr     (wr_addr),
        .wr_wea      (wr_wea),
        .wr_ena      (wr_ena),
        .fill_cnt    (fill_cnt),
        .buf_full    (buf_full),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int mon_err = 0;
    int n_strobes = 0;
    int n_done  = 0;

    logic        rdy_seen;
    logic [7:0]  ena_before;
    logic [31:0] mem [0:7][0:28];

    typedef struct packed {
        logic        s;
        logic        r;
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic [7:0]  ena;
        logic [7:0]  fill;
        logic        full;
    } vec_t;

    vec_t vecs [0:7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input logic s, input logic r, input logic v, input logic [31:0] d);
        @(negedge clk);
        start       = s;
        buf_release = r;
        in_valid    = v;
        in_data     = d;
        #1;
        rdy_seen   = in_ready;
        ena_before = wr_ena;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 29; a++)
                mem[b][a] = 32'hDEADBEEF;
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 29; a++)
                if (mem[b][a] !== 32'(8*a + b)) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    // Bank memory model fed from the write strobes, plus strobe sanity checks.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_ena[b]) begin
                    n_strobes++;
                    if (wr_addr[b*5 +: 5] >= 5'd29) mon_err++;
                    else mem[b][wr_addr[b*5 +: 5]] = wr_din[b*32 +: 32];
                end
            end
            if (wr_ena !== wr_wea) mon_err++;
            if ($countones(wr_ena) > 1) mon_err++;
            if (frame_done) begin
                n_done++;
                if (wr_ena !== 8'h80 || wr_addr[35 +: 5] !== 5'd28) mon_err++;
            end
        end
    end

    initial begin
        int s0, d0, bad, rdy_cnt;
        logic [7:0] exp_e;

        //            s     r     v     d          rdy   ena    fill  full
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'hAA,    1'b0, 8'h00, 8'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 8'h00, 8'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hBB,    1'b0, 8'h00, 8'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0,     1'b1, 8'h01, 8'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 8'h00, 8'd1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h1,     1'b1, 8'h02, 8'd2, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'hCC,    1'b0, 8'h00, 8'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h0,     1'b1, 8'h01, 8'd1, 1'b0};

        rst_n = 1'b0; start = 1'b0; buf_release = 1'b0; in_valid = 1'b0; in_data = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",   64'(in_ready),   64'd0);
        chk("rst_wr_ena",     64'(wr_ena),     64'd0);
        chk("rst_wr_wea",     64'(wr_wea),     64'd0);
        chk("rst_wr_din_lo",  wr_din[63:0],    64'd0);
        chk("rst_wr_addr",    64'(wr_addr),    64'd0);
        chk("rst_fill_cnt",   64'(fill_cnt),   64'd0);
        chk("rst_buf_full",   64'(buf_full),   64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].s, vecs[i].r, vecs[i].v, vecs[i].d);
            chk($sformatf("vec%0d_in_ready", i), 64'(rdy_seen), 64'(vecs[i].rdy));
            chk($sformatf("vec%0d_wr_ena", i),   64'(wr_ena),   64'(vecs[i].ena));
            chk($sformatf("vec%0d_fill_cnt", i), 64'(fill_cnt), 64'(vecs[i].fill));
            chk($sformatf("vec%0d_buf_full", i), 64'(buf_full), 64'(vecs[i].full));
        end

        // Back-to-back full frame
        clear_mem();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        s0 = n_strobes; d0 = n_done; rdy_cnt = 0;
        for (int k = 0; k < 232; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'(k));
            if (rdy_seen) rdy_cnt++;
        end
        chk("f1_frame_done", 64'(frame_done), 64'd1);
        chk("f1_buf_full",   64'(buf_full),   64'd1);
        chk("f1_fill_cnt",   64'(fill_cnt),   64'd232);
        chk("f1_last_ena",   64'(wr_ena),     64'h80);
        chk("f1_last_addr",  64'(wr_addr[35 +: 5]), 64'd28);
        chk("f1_ready_cnt",  64'(rdy_cnt),    64'd232);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'hFFFF);
            if (rdy_seen !== 1'b0 || wr_ena !== 8'h00 || frame_done !== 1'b0) bad++;
        end
        chk("full_hold_no_write", 64'(bad), 64'd0);
        chk("f1_strobes", 64'(n_strobes - s0), 64'd232);
        chk("f1_done_cnt", 64'(n_done - d0), 64'd1);
        check_mem("f1_contents");
        chk("full_fill_hold", 64'(fill_cnt), 64'd232);

        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rel_buf_full", 64'(buf_full), 64'd0);
        chk("rel_fill_cnt", 64'(fill_cnt), 64'd232);
        step(1'b0, 1'b0, 1'b1, 32'h5);
        chk("idle_in_ready", 64'(rdy_seen), 64'd0);
        chk("idle_wr_ena",   64'(wr_ena),   64'd0);

        // Throttled frame: valid 1,0,1,0...
        clear_mem();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        s0 = n_strobes; d0 = n_done; bad = 0;
        for (int k = 0; k < 232; k++) begin
            exp_e = 8'(1 << (k % 8));
            step(1'b0, 1'b0, 1'b1, 32'(k));
            if (wr_ena !== exp_e) bad++;
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (wr_ena !== 8'h00) bad++;
        end
        chk("f2_strobe_pattern", 64'(bad), 64'd0);
        chk("f2_buf_full", 64'(buf_full), 64'd1);
        chk("f2_fill_cnt", 64'(fill_cnt), 64'd232);
        chk("f2_strobes",  64'(n_strobes - s0), 64'd232);
        chk("f2_done_cnt", 64'(n_done - d0), 64'd1);
        check_mem("f2_contents");

        // start and release together in FULL
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("sr_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("sr_buf_full", 64'(buf_full), 64'd0);
        step(1'b0, 1'b0, 1'b1, 32'h77);
        chk("sr_in_ready", 64'(rdy_seen), 64'd1);
        chk("sr_wr_ena",   64'(wr_ena),   64'h01);
        chk("sr_din0",     64'(wr_din[31:0]), 64'h77);
        chk("sr_addr0",    64'(wr_addr[4:0]), 64'd0);

        // Restart after 50 words
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'b1, 32'(k + 100));
        chk("rs_fill50", 64'(fill_cnt), 64'd50);
        step(1'b1, 1'b0, 1'b1, 32'hDEAD);
        chk("rs_in_ready",  64'(rdy_seen),   64'd0);
        chk("rs_prev_strb", 64'(ena_before), 64'h02);
        chk("rs_wr_ena",    64'(wr_ena),     64'h00);
        chk("rs_fill_cnt",  64'(fill_cnt),   64'd0);
        step(1'b0, 1'b0, 1'b1, 32'hBEEF);
        chk("rs_next_ena",  64'(wr_ena),       64'h01);
        chk("rs_next_din",  64'(wr_din[31:0]), 64'hBEEF);
        chk("rs_next_addr", 64'(wr_addr[4:0]), 64'd0);
        chk("rs_next_fill", 64'(fill_cnt),     64'd1);

        // Asynchronous reset mid-fill
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 1'b1, 32'(k));
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd100;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_in_ready", 64'(in_ready), 64'd0);
        chk("ar_wr_ena",   64'(wr_ena),   64'd0);
        chk("ar_wr_din",   wr_din[63:0],  64'd0);
        chk("ar_wr_addr",  64'(wr_addr),  64'd0);
        chk("ar_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("ar_buf_full", 64'(buf_full), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h1);
        chk("ar_idle_ready", 64'(rdy_seen), 64'd0);
        chk("ar_idle_ena",   64'(wr_ena),   64'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h9);
        chk("ar_new_ena", 64'(wr_ena),       64'h01);
        chk("ar_new_din", 64'(wr_din[31:0]), 64'h9);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("monitor_errors", 64'(mon_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
